// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch-queue entry type and reset PC default
package fetch_pkg;

    localparam logic [63:0] FETCH_RESET_PC = 64'h0;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order fetch queue: allocate at tail, fill oldest unfilled, dequeue head
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int QDEPTH = 2,
    localparam int PW     = $clog2(QDEPTH),
    localparam int CW     = $clog2(QDEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_flush,
    input  logic          i_alloc,
    input  logic [63:0]   i_alloc_pc,
    input  logic          i_fill,
    input  logic [31:0]   i_fill_data,
    input  logic          i_deq,
    output logic [CW-1:0] o_count,
    output logic [CW-1:0] o_unfilled,
    output fetch_entry_t  o_head
);

    fetch_entry_t  r_mem [QDEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW-1:0] r_fill;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_unfilled;

    // Pointers are PW bits wide, so wrap modulo QDEPTH falls out of the width.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_fill     <= '0;
            r_count    <= '0;
            r_unfilled <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                r_mem[i].filled <= 1'b0;
            end
        end else begin
            if (i_alloc) begin
                r_mem[r_tail] <= '{pc: i_alloc_pc, instr: 32'h0, filled: 1'b0};
                r_tail        <= r_tail + PW'(1);
            end
            if (i_fill) begin
                r_mem[r_fill].instr  <= i_fill_data;
                r_mem[r_fill].filled <= 1'b1;
                r_fill               <= r_fill + PW'(1);
            end
            if (i_deq) begin
                r_head <= r_head + PW'(1);
            end
            r_count    <= r_count + CW'(i_alloc) - CW'(i_deq);
            r_unfilled <= r_unfilled + CW'(i_alloc) - CW'(i_fill);
        end
    end

    assign o_count    = r_count;
    assign o_unfilled = r_unfilled;
    assign o_head     = r_mem[r_head];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: request issue, redirect, stale-response drop, decode head
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = FETCH_RESET_PC,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        PCSrcE,
    input  logic [63:0] PCTargetE,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] instruction,
    output logic [63:0] PCF,
    output logic [63:0] PCPlus4F,
    output logic        FetchValidF
);

    localparam int CW = $clog2(QDEPTH + 1);

    logic [63:0]   r_reqpc;
    logic [CW-1:0] r_drop_cnt;

    logic [CW-1:0] w_count;
    logic [CW-1:0] w_unfilled;
    logic [CW-1:0] w_outstanding;
    fetch_entry_t  w_head;
    logic          w_req_valid;
    logic          w_accept;
    logic          w_fill;
    logic          w_valid;
    logic          w_deq;
    logic          w_unused_tgt;

    assign w_req_valid = !rst && (w_count < CW'(QDEPTH)) && (r_drop_cnt == '0) && !PCSrcE;
    assign w_accept    = w_req_valid && imem_req_ready;
    assign w_fill      = !rst && !PCSrcE && imem_rsp_valid && (r_drop_cnt == '0) && (w_unfilled != '0);
    assign w_valid     = !rst && w_head.filled && (w_count != '0);
    assign w_deq       = w_valid && !StallF && !PCSrcE;

    // Requests are only issued while drop_cnt is zero, so this sum never exceeds QDEPTH.
    assign w_outstanding = r_drop_cnt + w_unfilled;
    assign w_unused_tgt  = ^PCTargetE[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_reqpc    <= RESET_PC;
            r_drop_cnt <= '0;
        end else if (PCSrcE) begin
            r_reqpc    <= {PCTargetE[63:2], 2'b00};
            r_drop_cnt <= (imem_rsp_valid && (w_outstanding != '0)) ? w_outstanding - CW'(1)
                                                                     : w_outstanding;
        end else begin
            if (w_accept) begin
                r_reqpc <= r_reqpc + 64'd4;
            end
            if (imem_rsp_valid && (r_drop_cnt != '0)) begin
                r_drop_cnt <= r_drop_cnt - CW'(1);
            end
        end
    end

    fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (PCSrcE),
        .i_alloc     (w_accept),
        .i_alloc_pc  (r_reqpc),
        .i_fill      (w_fill),
        .i_fill_data (imem_rsp_data),
        .i_deq       (w_deq),
        .o_count     (w_count),
        .o_unfilled  (w_unfilled),
        .o_head      (w_head)
    );

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = rst ? RESET_PC : r_reqpc;
    assign FetchValidF    = w_valid;
    assign instruction    = w_valid ? w_head.instr : 32'h0;
    assign PCF            = w_valid ? w_head.pc : 64'h0;
    assign PCPlus4F       = w_valid ? w_head.pc + 64'd4 : 64'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        StallF;
    logic        PCSrcE;
    logic [63:0] PCTargetE;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic [31:0] instruction;
    logic [63:0] PCF;
    logic [63:0] PCPlus4F;
    logic        FetchValidF;

    logic        w2_req_valid;
    logic [63:0] w2_req_addr;
    logic [31:0] w2_instruction;
    logic [63:0] w2_pcf;
    logic [63:0] w2_pcp4;
    logic        w2_valid;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] pending [$];
    bit          mem_hold;
    logic [63:0] exp_pc;
    logic [63:0] exp_req;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .instruction(instruction), .PCF(PCF),
        .PCPlus4F(PCPlus4F), .FetchValidF(FetchValidF)
    );

    fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .imem_req_valid(w2_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(w2_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .instruction(w2_instruction), .PCF(w2_pcf),
        .PCPlus4F(w2_pcp4), .FetchValidF(w2_valid)
    );

    function automatic logic [31:0] mk(input logic [63:0] a);
        return {a[31:2], 2'b11} ^ 32'h5A00_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic refresh_rsp();
        if (!rst && !mem_hold && pending.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mk(pending[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    endtask

    task automatic step();
        bit          acc;
        bit          rv;
        bit          deq;
        logic [63:0] a;
        acc = imem_req_valid && imem_req_ready;
        a   = imem_req_addr;
        rv  = imem_rsp_valid;
        deq = !rst && FetchValidF && !StallF && !PCSrcE;
        if (!rst && FetchValidF) check("head_ins", 64'(instruction), 64'(mk(PCF)));
        if (deq) begin
            check("deq_pc", PCF, exp_pc);
            check("deq_pc4", PCPlus4F, exp_pc + 64'd4);
        end
        if (acc) check("req_addr", a, exp_req);
        @(posedge clk);
        #1;
        if (rst) begin
            pending.delete();
            exp_pc  = 64'h0;
            exp_req = 64'h0;
        end else begin
            if (rv) void'(pending.pop_front());
            if (acc) pending.push_back(a);
            if (PCSrcE) begin
                exp_pc  = {PCTargetE[63:2], 2'b00};
                exp_req = exp_pc;
            end else begin
                if (deq) exp_pc = exp_pc + 64'd4;
                if (acc) exp_req = exp_req + 64'd4;
            end
        end
        refresh_rsp();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = 64'h0;
        imem_req_ready = 1'b1; mem_hold = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        exp_pc = 64'h0; exp_req = 64'h0;
        #1;
        step();
        step();
        check("rst_req_valid", 64'(imem_req_valid), 64'h0);
        check("rst_valid", 64'(FetchValidF), 64'h0);
        check("rst_pcf", PCF, 64'h0);
        check("rst_pc4", PCPlus4F, 64'h0);
        check("rst_ins", 64'(instruction), 64'h0);
        check("rst_addr", imem_req_addr, 64'h0);
        check("rst_addr_wrap", w2_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        check("rst_wrap_outs", {w2_pcf[31:0], w2_instruction} | w2_pcp4 | 64'({w2_valid, w2_req_valid}), 64'h0);

        rst = 1'b0;
        #1;
        check("first_req_valid", 64'(imem_req_valid), 64'h1);
        check("first_addr", imem_req_addr, 64'h0);
        check("first_valid", 64'(FetchValidF), 64'h0);
        step();
        check("second_addr", imem_req_addr, 64'h4);
        check("wrap_second_addr", w2_req_addr, 64'h0);
        check("n1_valid", 64'(FetchValidF), 64'h0);
        step();
        check("n2_valid", 64'(FetchValidF), 64'h1);
        check("n2_pcf", PCF, 64'h0);
        check("n2_pc4", PCPlus4F, 64'h4);
        check("n2_ins", 64'(instruction), 64'(mk(64'h0)));
        repeat (4) step();

        StallF = 1'b1;
        #1;
        check("stall_start_pc", PCF, 64'hC);
        repeat (3) begin
            check("stall_pc", PCF, exp_pc);
            check("stall_valid", 64'(FetchValidF), 64'h1);
            step();
        end
        check("stall_full_req", 64'(imem_req_valid), 64'h0);
        check("stall_end_pc", PCF, 64'hC);
        StallF = 1'b0;
        #1;
        repeat (6) step();

        mem_hold = 1'b1;
        refresh_rsp();
        #1;
        repeat (4) step();
        check("hold_valid", 64'(FetchValidF), 64'h0);
        check("hold_req", 64'(imem_req_valid), 64'h0);
        PCSrcE = 1'b1; PCTargetE = 64'h1002;
        #1;
        check("redir_req", 64'(imem_req_valid), 64'h0);
        step();
        PCSrcE = 1'b0; mem_hold = 1'b0;
        refresh_rsp();
        #1;
        check("drop1_req", 64'(imem_req_valid), 64'h0);
        check("drop1_valid", 64'(FetchValidF), 64'h0);
        step();
        check("drop2_req", 64'(imem_req_valid), 64'h0);
        step();
        check("redir_req_valid", 64'(imem_req_valid), 64'h1);
        check("redir_addr", imem_req_addr, 64'h1000);
        step();
        step();
        check("redir_valid", 64'(FetchValidF), 64'h1);
        check("redir_pcf", PCF, 64'h1000);
        check("redir_ins", 64'(instruction), 64'(mk(64'h1000)));

        mem_hold = 1'b1;
        refresh_rsp();
        #1;
        repeat (4) step();
        mem_hold = 1'b0;
        refresh_rsp();
        PCSrcE = 1'b1; PCTargetE = 64'h2000;
        #1;
        step();
        PCSrcE = 1'b0;
        #1;
        check("same_drop_req", 64'(imem_req_valid), 64'h0);
        step();
        check("same_req_valid", 64'(imem_req_valid), 64'h1);
        check("same_addr", imem_req_addr, 64'h2000);
        step();
        step();
        check("same_valid", 64'(FetchValidF), 64'h1);
        check("same_pcf", PCF, 64'h2000);
        check("same_ins", 64'(instruction), 64'(mk(64'h2000)));

        repeat (3) step();
        imem_req_ready = 1'b0;
        #1;
        repeat (5) begin
            check("nready_addr", imem_req_addr, exp_req);
            step();
        end
        check("drained_valid", 64'(FetchValidF), 64'h0);
        check("drained_ins", 64'(instruction), 64'h0);
        check("drained_pcf", PCF, 64'h0);
        check("drained_addr", imem_req_addr, exp_req);
        imem_req_ready = 1'b1;
        #1;
        repeat (6) step();

        rst = 1'b1;
        refresh_rsp();
        #1;
        check("mid_rst_req", 64'(imem_req_valid), 64'h0);
        check("mid_rst_addr", imem_req_addr, 64'h0);
        check("mid_rst_valid", 64'(FetchValidF), 64'h0);
        step();
        check("mid_rst_pcf", PCF, 64'h0);
        rst = 1'b0;
        #1;
        check("post_rst_req", 64'(imem_req_valid), 64'h1);
        check("post_rst_addr", imem_req_addr, 64'h0);
        step();
        step();
        check("post_rst_valid", 64'(FetchValidF), 64'h1);
        check("post_rst_pcf", PCF, 64'h0);
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
